vga_timing_gen: RTL and testbench

- Generates 640x480 VGA raster timing for the Pong full-game design.
- Drives the horizontal/vertical pixel counts consumed by the paddle, ball and score draw blocks.
- Collects their registered draw flags back and composes the final RGB pixel.
- Delays HSync/VSync/active to match the draw-block latency, so sync and colour leave the block aligned at the connector.

---
 rtl/pong_vga_pkg.sv | 18 +
 rtl/sync_delay_line.sv | 22 ++
 rtl/vga_timing_gen.sv | 101 ++++++++++
 tb/tb_vga_timing_gen.sv | 126 ++++++++++++
 4 files changed

// File: rtl/pong_vga_pkg.sv
// pong_vga_pkg: 640x480 VGA timing constants and sync bundle shared by the Pong video blocks.
package pong_vga_pkg;
  localparam int VIDEO_WIDTH = 3;
  localparam int HMAX = 800;
  localparam int VMAX = 525;
  localparam int HDISPLAY = 640;
  localparam int VDISPLAY = 480;
  localparam int H_FRONT = 16;
  localparam int H_SYNC = 96;
  localparam int V_FRONT = 10;
  localparam int V_SYNC = 2;
  typedef struct packed {
    logic hs_n;
    logic vs_n;
    logic act;
  } sync_t;
  localparam sync_t SYNC_IDLE = '{hs_n: 1'b1, vs_n: 1'b1, act: 1'b0};
endpackage

// File: rtl/sync_delay_line.sv
// sync_delay_line: DEPTH-stage shift register whose stages all load rst_val on async reset.
module sync_delay_line #(
  parameter int W = 1,
  parameter int DEPTH = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] rst_val,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);
  logic [W-1:0] stage_q [DEPTH];
  logic [W-1:0] stage_d [DEPTH];
  always_comb begin
    stage_d[0] = d;
    for (int i = 1; i < DEPTH; i++) stage_d[i] = stage_q[i-1];
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) for (int i = 0; i < DEPTH; i++) stage_q[i] <= rst_val;
    else stage_q <= stage_d;
  assign q = stage_q[DEPTH-1];
endmodule

// File: rtl/vga_timing_gen.sv
// vga_timing_gen: VGA raster counters, sync decode aligned to draw-block latency, and RGB composition.
module vga_timing_gen
  import pong_vga_pkg::*;
#(
  parameter int VIDEO_WIDTH = pong_vga_pkg::VIDEO_WIDTH,
  parameter int HMAX = pong_vga_pkg::HMAX,
  parameter int VMAX = pong_vga_pkg::VMAX,
  parameter int HDISPLAY = pong_vga_pkg::HDISPLAY,
  parameter int VDISPLAY = pong_vga_pkg::VDISPLAY,
  parameter int H_FRONT = pong_vga_pkg::H_FRONT,
  parameter int H_SYNC = pong_vga_pkg::H_SYNC,
  parameter int V_FRONT = pong_vga_pkg::V_FRONT,
  parameter int V_SYNC = pong_vga_pkg::V_SYNC,
  parameter int NUM_LAYERS = 3,
  parameter int DRAW_LATENCY = 1,
  localparam int HW = $clog2(HMAX),
  localparam int VW = $clog2(VMAX)
) (
  input  logic                   i_Clk,
  input  logic                   i_Reset,
  input  logic                   i_Enable,
  input  logic [NUM_LAYERS-1:0]  i_Draw,
  output logic [HW-1:0]          o_H_count,
  output logic [VW-1:0]          o_V_count,
  output logic                   o_Frame_Done,
  output logic                   o_HSync,
  output logic                   o_VSync,
  output logic                   o_Active,
  output logic [VIDEO_WIDTH-1:0] o_Red,
  output logic [VIDEO_WIDTH-1:0] o_Green,
  output logic [VIDEO_WIDTH-1:0] o_Blue
);
  localparam logic [HW-1:0] H_LAST = HW'(HMAX - 1);
  localparam logic [HW-1:0] H_VIS = HW'(HDISPLAY);
  localparam logic [HW-1:0] HS_ON = HW'(HDISPLAY + H_FRONT);
  localparam logic [HW-1:0] HS_OFF = HW'(HDISPLAY + H_FRONT + H_SYNC);
  localparam logic [VW-1:0] V_LAST = VW'(VMAX - 1);
  localparam logic [VW-1:0] V_VIS = VW'(VDISPLAY);
  localparam logic [VW-1:0] VS_ON = VW'(VDISPLAY + V_FRONT);
  localparam logic [VW-1:0] VS_OFF = VW'(VDISPLAY + V_FRONT + V_SYNC);

  if (HDISPLAY + H_FRONT + H_SYNC > HMAX) begin : g_bad_h
    $error("horizontal display+porch+sync exceeds HMAX");
  end
  if (VDISPLAY + V_FRONT + V_SYNC > VMAX) begin : g_bad_v
    $error("vertical display+porch+sync exceeds VMAX");
  end
  if (DRAW_LATENCY < 1) begin : g_bad_lat
    $error("DRAW_LATENCY must be at least 1");
  end

  logic [HW-1:0] h_q, h_d;
  logic [VW-1:0] v_q, v_d;
  sync_t sync_raw, sync_dly, sync_q, sync_d;
  logic rgb_q, rgb_d;

  always_comb begin
    h_d = (h_q == H_LAST) ? '0 : h_q + 1'b1;
    v_d = (h_q != H_LAST) ? v_q : (v_q == V_LAST) ? '0 : v_q + 1'b1;
    sync_raw.hs_n = !(h_q >= HS_ON && h_q < HS_OFF);
    sync_raw.vs_n = !(v_q >= VS_ON && v_q < VS_OFF);
    sync_raw.act = (h_q < H_VIS) && (v_q < V_VIS);
    sync_d = sync_dly;
    rgb_d = sync_dly.act && i_Enable && |i_Draw;
  end

  // The last delay stage lines up with the returning draw flags.
  sync_delay_line #(
    .W($bits(sync_t)),
    .DEPTH(DRAW_LATENCY)
  ) u_sync_dly (
    .clk(i_Clk),
    .rst(i_Reset),
    .rst_val(SYNC_IDLE),
    .d(sync_raw),
    .q(sync_dly)
  );

  always_ff @(posedge i_Clk or posedge i_Reset)
    if (i_Reset) begin
      h_q <= '0;
      v_q <= '0;
      sync_q <= SYNC_IDLE;
      rgb_q <= 1'b0;
    end else begin
      h_q <= h_d;
      v_q <= v_d;
      sync_q <= sync_d;
      rgb_q <= rgb_d;
    end

  assign o_H_count = h_q;
  assign o_V_count = v_q;
  assign o_Frame_Done = (h_q == '0) && (v_q == V_VIS);
  assign o_HSync = sync_q.hs_n;
  assign o_VSync = sync_q.vs_n;
  assign o_Active = sync_q.act;
  assign o_Red = {VIDEO_WIDTH{rgb_q}};
  assign o_Green = {VIDEO_WIDTH{rgb_q}};
  assign o_Blue = {VIDEO_WIDTH{rgb_q}};
endmodule

// File: tb/tb_vga_timing_gen.sv
// tb_vga_timing_gen: checks a default and a shrunken-timing instance against an arithmetic raster model.
module tb_vga_timing_gen;
  import pong_vga_pkg::*;
  localparam int S_HM = 50, S_VM = 30, S_HD = 32, S_VD = 20;
  localparam int S_HF = 4, S_HS = 6, S_VF = 2, S_VS = 3, S_L = 2;

  logic clk = 1'b0, rst = 1'b1, en = 1'b0;
  logic [2:0] draw = 3'b000;
  logic [9:0] h0, v0;
  logic [5:0] h1;
  logic [4:0] v1;
  logic fd0, hs0, vs0, ac0, fd1, hs1, vs1, ac1;
  logic [2:0] r0, g0, b0, r1, g1, b1;
  logic [3:0] hist [8192];
  logic count_fd = 1'b0;
  int p = 0, total = 0, bad = 0, fd_cnt = 0;

  always #5 clk = ~clk;

  vga_timing_gen u0 (
    .i_Clk(clk), .i_Reset(rst), .i_Enable(en), .i_Draw(draw),
    .o_H_count(h0), .o_V_count(v0), .o_Frame_Done(fd0),
    .o_HSync(hs0), .o_VSync(vs0), .o_Active(ac0),
    .o_Red(r0), .o_Green(g0), .o_Blue(b0)
  );

  vga_timing_gen #(
    .HMAX(S_HM), .VMAX(S_VM), .HDISPLAY(S_HD), .VDISPLAY(S_VD),
    .H_FRONT(S_HF), .H_SYNC(S_HS), .V_FRONT(S_VF), .V_SYNC(S_VS),
    .DRAW_LATENCY(S_L)
  ) u1 (
    .i_Clk(clk), .i_Reset(rst), .i_Enable(en), .i_Draw(draw),
    .o_H_count(h1), .o_V_count(v1), .o_Frame_Done(fd1),
    .o_HSync(hs1), .o_VSync(vs1), .o_Active(ac1),
    .o_Red(r1), .o_Green(g1), .o_Blue(b1)
  );

  // {hs_n, vs_n, act} of the q-th count since reset; before the first count everything is idle.
  function automatic logic [2:0] raw_ref(input int hm, vm, hd, vd, hf, hs, vf, vs, q);
    int h, v;
    if (q < 0) return 3'b110;
    h = q % hm;
    v = (q / hm) % vm;
    return {!(h >= hd + hf && h < hd + hf + hs), !(v >= vd + vf && v < vd + vf + vs), h < hd && v < vd};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s p=%0d got=%0h want=%0h", tag, p, obs, exp);
    end
  endtask

  task automatic chk_inst(input string nm, input int hm, vm, hd, vd, hf, hs, vf, vs, l,
                          input logic [9:0] hc, vc, input logic fd, hsy, vsy, act,
                          input logic [2:0] r, g, b);
    logic [2:0] s;
    logic on;
    s = raw_ref(hm, vm, hd, vd, hf, hs, vf, vs, p - l - 1);
    on = (p >= 1) ? (s[0] && hist[p-1][3] && |hist[p-1][2:0]) : 1'b0;
    chk({nm, ".hcount"}, 32'(hc), p % hm);
    chk({nm, ".vcount"}, 32'(vc), (p / hm) % vm);
    chk({nm, ".frame_done"}, 32'(fd), 32'((p % hm) == 0 && (p / hm) % vm == vd));
    chk({nm, ".hsync"}, 32'(hsy), 32'(s[2]));
    chk({nm, ".vsync"}, 32'(vsy), 32'(s[1]));
    chk({nm, ".active"}, 32'(act), 32'(s[0]));
    chk({nm, ".rgb"}, 32'({r, g, b}), 32'({9{on}}));
  endtask

  task automatic check_now();
    chk_inst("small", S_HM, S_VM, S_HD, S_VD, S_HF, S_HS, S_VF, S_VS, S_L,
             10'(h1), 10'(v1), fd1, hs1, vs1, ac1, r1, g1, b1);
    if (p < 1700)
      chk_inst("vga", HMAX, VMAX, HDISPLAY, VDISPLAY, H_FRONT, H_SYNC, V_FRONT, V_SYNC, 1,
               h0, v0, fd0, hs0, vs0, ac0, r0, g0, b0);
  endtask

  // mode 0: random enable/draw; 1: enable off, all layers drawing; 2: single-layer flags for counts (5,5) and (40,5)
  task automatic step(input int mode);
    logic e;
    logic [2:0] d;
    int t;
    check_now();
    if (count_fd && fd1 === 1'b1) fd_cnt++;
    t = p - S_L;
    e = 1'b1;
    d = 3'b000;
    if (mode == 0) begin
      e = $urandom_range(3) != 0;
      d = 3'($urandom) & 3'($urandom);
    end else if (mode == 1) begin
      e = 1'b0;
      d = 3'b111;
    end else if (t >= 0 && (t / S_HM) % S_VM == 5 && (t % S_HM == 5 || t % S_HM == 40)) begin
      d = 3'b010;
    end
    en = e;
    draw = d;
    hist[p] = {e, d};
    @(negedge clk);
    p++;
  endtask

  initial begin
    repeat (3) @(negedge clk);
    check_now();
    rst = 1'b0;
    count_fd = 1'b1;
    for (int i = 0; i < 3 * S_HM * S_VM; i++) step(0);
    count_fd = 1'b0;
    chk("frame_done_3_frames", 32'(fd_cnt), 3);
    for (int i = 0; i < 730; i++) step(0);
    rst = 1'b1;
    #1;
    p = 0;
    check_now();
    @(negedge clk);
    check_now();
    rst = 1'b0;
    for (int i = 0; i < S_HM * S_VM; i++) step(1);
    for (int i = 0; i < S_HM * S_VM; i++) step(2);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
